// File: rtl/sdram_write_sequencer.sv
// Single-word SDRAM write sequencer: ACTIVE -> WRITE -> PRECHARGE per accepted request.
// Define SDRAM_WRITE_REFRESH_EN to compile in AUTO REFRESH (REF/WAIT_RFC, REFRESH_REQ/REFRESH_ACK).
module sdram_write_sequencer #(
  parameter int T_RCD = 2,
  parameter int T_WR  = 2,
  parameter int T_RP  = 2,
  parameter int T_RFC = 7
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        INIT_DONE,
  input  logic        WR_REQ,
  input  logic [15:0] WR_DATA,
  input  logic [1:0]  BA_IN,
  input  logic [12:0] ROW_IN,
  input  logic [8:0]  COL_IN,
  input  logic        REFRESH_REQ,
  output logic        WR_ACK,
  output logic        NEXT,
  output logic        REFRESH_ACK,
  output logic        BUSY,
  output logic        CS_N,
  output logic        RAS_N,
  output logic        CAS_N,
  output logic        WE_N,
  output logic [1:0]  BA,
  output logic [12:0] ADDR,
  output logic [15:0] DQ_OUT,
  output logic        DQ_OE,
  output logic [1:0]  DQM
);
  typedef enum logic [3:0] {
    IDLE, ACT, WAIT_RCD, WR, WAIT_WR, PRE, WAIT_RP
`ifdef SDRAM_WRITE_REFRESH_EN
    , REF, WAIT_RFC
`endif
  } state_t;

  typedef struct packed {
    logic [1:0]  ba;
    logic [12:0] row;
    logic [8:0]  col;
    logic [15:0] data;
  } wr_req_t;

  typedef logic [7:0] cnt_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  wr_req_t     req_q, req_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [12:0] addr_q, addr_d;
  logic [15:0] dq_q, dq_d;
  logic        oe_q, oe_d;
  logic [1:0]  dqm_q, dqm_d;
  logic        ack_q, ack_d;
  logic        next_q, next_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    // Wait states leave when the counter reaches zero; it counts remaining cycles minus one.
    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
`ifdef SDRAM_WRITE_REFRESH_EN
        if (INIT_DONE && REFRESH_REQ) state_d = REF;
        else
`endif
        if (INIT_DONE && WR_REQ) begin
          state_d = ACT;
          req_d   = '{ba: BA_IN, row: ROW_IN, col: COL_IN, data: WR_DATA};
        end
      end
      ACT: begin
        if (T_RCD == 1) state_d = WR;
        else begin
          state_d = WAIT_RCD;
          cnt_d   = cnt_t'(T_RCD - 2);
        end
      end
      WAIT_RCD: if (cnt_q == '0) state_d = WR;
      WR: begin
        state_d = WAIT_WR;
        cnt_d   = cnt_t'(T_WR - 1);
      end
      WAIT_WR: if (cnt_q == '0) state_d = PRE;
      PRE: begin
        if (T_RP == 1) state_d = IDLE;
        else begin
          state_d = WAIT_RP;
          cnt_d   = cnt_t'(T_RP - 2);
        end
      end
      WAIT_RP: if (cnt_q == '0) state_d = IDLE;
`ifdef SDRAM_WRITE_REFRESH_EN
      REF: begin
        if (T_RFC == 1) state_d = IDLE;
        else begin
          state_d = WAIT_RFC;
          cnt_d   = cnt_t'(T_RFC - 2);
        end
      end
      WAIT_RFC: if (cnt_q == '0) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Pins are decoded from the next state so every output is registered alongside the state.
  always_comb begin
    cmd_d  = CMD_NOP;
    ba_d   = ba_q;
    addr_d = addr_q;
    dq_d   = dq_q;
    oe_d   = 1'b0;
    dqm_d  = 2'b11;
    case (state_d)
      ACT: begin
        cmd_d  = CMD_ACT;
        ba_d   = req_d.ba;
        addr_d = req_d.row;
      end
      WR: begin
        cmd_d  = CMD_WR;
        ba_d   = req_d.ba;
        addr_d = {4'b0000, req_d.col};
        dq_d   = req_d.data;
        oe_d   = 1'b1;
        dqm_d  = 2'b00;
      end
      PRE: begin
        cmd_d  = CMD_PRE;
        addr_d = 13'h0400;
      end
`ifdef SDRAM_WRITE_REFRESH_EN
      REF: cmd_d = CMD_REF;
`endif
      default: ;
    endcase
    ack_d  = (state_q == IDLE) && (state_d == ACT);
    next_d = (state_q == WR);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      cmd_q   <= CMD_NOP;
      ba_q    <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      dqm_q   <= 2'b11;
      ack_q   <= 1'b0;
      next_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      dqm_q   <= dqm_d;
      ack_q   <= ack_d;
      next_q  <= next_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SDRAM_WRITE_REFRESH_EN
  logic ref_ack_q;
  always_ff @(posedge CLK) begin
    if (RESET) ref_ack_q <= 1'b0;
    else       ref_ack_q <= (state_q == IDLE) && (state_d == REF);
  end
  assign REFRESH_ACK = ref_ack_q;
`else
  logic unused_refresh_req;
  assign unused_refresh_req = REFRESH_REQ;
  assign REFRESH_ACK = 1'b0;
`endif

  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_q;
  assign BA     = ba_q;
  assign ADDR   = addr_q;
  assign DQ_OUT = dq_q;
  assign DQ_OE  = oe_q;
  assign DQM    = dqm_q;
  assign WR_ACK = ack_q;
  assign NEXT   = next_q;
  assign BUSY   = busy_q;

endmodule
